bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq.sv | 170 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : bin2bcd_seq
// Description : Sequential 20-bit binary to 6-digit BCD converter for a scan
//               display. Serial double-dabble (one bit per clock), followed
//               by a format cycle that adds sign, blanking and overflow dashes.
//               Optional build macro LZ_BLANK_EN: leading-zero blanking with
//               a floating minus sign.
// Revision    : 1.0 - initial release
// ============================================================================
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [19:0] bin_in,
    input  logic        neg,
    output logic        busy,
    output logic        done,
    output logic [23:0] bcd_out,
    output logic        ovf
);

    localparam logic [4:0] c_LAST_SHIFT = 5'd19;
    localparam logic [3:0] c_DASH       = 4'hA;
    localparam logic [3:0] c_BLANK      = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FMT   = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [19:0] r_bin;      // magnitude, shifted out MSB first
    logic        r_neg;      // captured sign
    logic [23:0] r_acc;      // six-digit BCD accumulator
    logic [4:0]  r_cnt;      // shift counter
    logic        r_carry;    // sticky: a bit left the 6-digit accumulator (value >= 1000000)

    logic [23:0] w_adj;
    logic        w_ovf;
    logic        w_neg_eff;
    logic [23:0] w_fmt;

    assign busy = (r_state != IDLE);

    // Overflow: a carry past six digits, or a nonzero sixth digit when the sign needs that slot.
    assign w_ovf     = r_carry | (r_neg & (r_acc[23:20] != 4'd0));
    // Negative zero is shown as plain zero.
    assign w_neg_eff = r_neg & (r_acc != 24'd0);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: start honoured only in IDLE, 20 shifts, one format cycle.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == c_LAST_SHIFT) w_state_next = FMT;
            FMT:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Double-dabble correction: add 3 to every digit that is 5 or more before shifting.
    always_comb begin
        w_adj = r_acc;
        for (int i = 0; i < 6; i++) begin
            if (r_acc[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_acc[i*4 +: 4] + 4'd3;
            end
        end
    end

`ifdef LZ_BLANK_EN
    logic [5:0] w_blank;
    logic       w_seen;

    // Mark leading zero digits; the rightmost digit is never blanked.
    always_comb begin
        w_blank = 6'b0;
        w_seen  = 1'b0;
        for (int i = 5; i >= 1; i--) begin
            if (!w_seen && (r_acc[i*4 +: 4] == 4'd0)) begin
                w_blank[i] = 1'b1;
            end else begin
                w_seen = 1'b1;
            end
        end
    end

    // Display format: dashes on overflow, otherwise blanking with the sign just left of the first numeral.
    always_comb begin
        w_fmt = r_acc;
        if (w_ovf) begin
            w_fmt = {6{c_DASH}};
        end else begin
            for (int i = 1; i < 6; i++) begin
                if (w_blank[i]) begin
                    w_fmt[i*4 +: 4] = c_BLANK;
                end
                if (w_neg_eff && w_blank[i] && !w_blank[i-1]) begin
                    w_fmt[i*4 +: 4] = c_DASH;
                end
            end
        end
    end
`else
    // Display format: dashes on overflow, otherwise zero-padded with the sign in the leftmost digit.
    always_comb begin
        w_fmt = r_acc;
        if (w_ovf) begin
            w_fmt = {6{c_DASH}};
        end else if (w_neg_eff) begin
            w_fmt[23:20] = c_DASH;
        end
    end
`endif

    // Datapath: capture on start, shift during SHIFT, publish results in FMT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bin   <= 20'd0;
            r_neg   <= 1'b0;
            r_acc   <= 24'd0;
            r_cnt   <= 5'd0;
            r_carry <= 1'b0;
            done    <= 1'b0;
            bcd_out <= 24'd0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= bin_in;
                        r_neg   <= neg;
                        r_acc   <= 24'd0;
                        r_cnt   <= 5'd0;
                        r_carry <= 1'b0;
                    end
                end
                SHIFT: begin
                    r_acc   <= {w_adj[22:0], r_bin[19]};
                    r_bin   <= {r_bin[18:0], 1'b0};
                    r_carry <= r_carry | w_adj[23];
                    r_cnt   <= r_cnt + 5'd1;
                end
                FMT: begin
                    bcd_out <= w_fmt;
                    ovf     <= w_ovf;
                    done    <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin2bcd_seq
// Description : Directed self-checking bench for bin2bcd_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bin2bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [19:0] bin_in = 20'd0;
    logic        neg = 1'b0;
    logic        busy;
    logic        done;
    logic [23:0] bcd_out;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    bin2bcd_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bin_in  (bin_in),
        .neg     (neg),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One conversion: start accepted at the next edge, done expected 21 edges later.
    task automatic convert(input logic [19:0] b, input logic n, input logic [23:0] eb,
                           input logic eo, input string tag);
        logic [23:0] prev_bcd;
        logic        prev_ovf;
        int          lat;
        logic        ok_busy;
        logic        ok_hold;
        prev_bcd = bcd_out;
        prev_ovf = ovf;
        bin_in   = b;
        neg      = n;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        bin_in   = ~b;
        neg      = ~n;
        lat      = 0;
        ok_busy  = 1'b1;
        ok_hold  = 1'b1;
        while (!done && lat < 40) begin
            if (busy !== 1'b1) ok_busy = 1'b0;
            if (bcd_out !== prev_bcd || ovf !== prev_ovf) ok_hold = 1'b0;
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 21);
        chk({tag, " busy"}, {31'd0, ok_busy}, 32'd1);
        chk({tag, " hold"}, {31'd0, ok_hold}, 32'd1);
        chk({tag, " bcd"}, {8'd0, bcd_out}, {8'd0, eb});
        chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({tag, " busy_at_done"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, " done_width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        int first_done;
        int second_done;
        int ndone;

        // Reset state
        tick(); tick(); tick();
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst done", {31'd0, done}, 32'd0);
        chk("rst ovf", {31'd0, ovf}, 32'd0);
        chk("rst bcd", {8'd0, bcd_out}, 32'd0);
        rst = 1'b0;
        tick();

        convert(20'd123456, 1'b0, 24'h123456, 1'b0, "pos123456");
`ifdef LZ_BLANK_EN
        convert(20'd42,     1'b1, 24'hFFFA42, 1'b0, "neg42");
        convert(20'd0,      1'b1, 24'hFFFFF0, 1'b0, "negzero");
        convert(20'd0,      1'b0, 24'hFFFFF0, 1'b0, "poszero");
        convert(20'd7,      1'b0, 24'hFFFFF7, 1'b0, "pos7");
        convert(20'd305,    1'b1, 24'hFFA305, 1'b0, "neg305");
`else
        convert(20'd42,     1'b1, 24'hA00042, 1'b0, "neg42");
        convert(20'd0,      1'b1, 24'h000000, 1'b0, "negzero");
        convert(20'd0,      1'b0, 24'h000000, 1'b0, "poszero");
        convert(20'd7,      1'b0, 24'h000007, 1'b0, "pos7");
        convert(20'd305,    1'b1, 24'hA00305, 1'b0, "neg305");
`endif
        convert(20'd1000000, 1'b0, 24'hAAAAAA, 1'b1, "ovf_pos");
        convert(20'd100000,  1'b1, 24'hAAAAAA, 1'b1, "ovf_neg");
        convert(20'd1048575, 1'b0, 24'hAAAAAA, 1'b1, "ovf_max");
        convert(20'd999999,  1'b0, 24'h999999, 1'b0, "max_pos");
        convert(20'd99999,   1'b1, 24'hA99999, 1'b0, "max_neg");
        convert(20'd500000,  1'b0, 24'h500000, 1'b0, "pos500000");

        // Back-to-back: pulse during busy ignored, pulse in the done cycle accepted
        bin_in = 20'd111;
        neg    = 1'b0;
        start  = 1'b1;
        tick();
        ndone       = 0;
        first_done  = -1;
        second_done = -1;
        for (int e = 1; e <= 60; e++) begin
            start  = (e == 6 || e == 22);
            bin_in = (e == 22) ? 20'd222 : 20'd987654;
            tick();
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = e;
                else if (second_done < 0) second_done = e;
            end
            if (e == 21) begin
`ifdef LZ_BLANK_EN
                chk("b2b first bcd", {8'd0, bcd_out}, 32'h00FFF111);
`else
                chk("b2b first bcd", {8'd0, bcd_out}, 32'h00000111);
`endif
            end
        end
        start = 1'b0;
        chk("b2b done count", ndone, 2);
        chk("b2b first edge", first_done, 21);
        chk("b2b second edge", second_done, 43);
`ifdef LZ_BLANK_EN
        chk("b2b second bcd", {8'd0, bcd_out}, 32'h00FFF222);
`else
        chk("b2b second bcd", {8'd0, bcd_out}, 32'h00000222);
`endif

        // Reset during SHIFT aborts; a start right after reset converts normally
        bin_in = 20'd555555;
        neg    = 1'b0;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        for (int e = 1; e <= 9; e++) tick();
        rst = 1'b1;
        tick();
        chk("abort busy", {31'd0, busy}, 32'd0);
        chk("abort done", {31'd0, done}, 32'd0);
        chk("abort ovf", {31'd0, ovf}, 32'd0);
        chk("abort bcd", {8'd0, bcd_out}, 32'd0);
        rst = 1'b0;
        convert(20'd654321, 1'b0, 24'h654321, 1'b0, "after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
